password_controller: RTL and testbench

Second login stage, directly downstream of the user-ID controller. Once the user ID matches, it collects a 4-digit password from the keypad and fetches the stored password for that user from a password ROM. It then compares the two, allowing up to three attempts. It grants the session with `PassOK`, or forces a logout back to the ID stage on lockout or user request; guests bypass password entry.

---
 rtl/pass_pkg.sv | 47 ++++
 rtl/password_controller_if.sv | 24 ++
 rtl/pass_rom.sv | 23 ++
 rtl/password_controller.sv | 154 +++++++++++++++
 tb/tb_password_controller.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pass_pkg.sv
// Shared types and sizing for the password login stage.
package pass_pkg;

   localparam int MAX_ATTEMPTS_DEF = 3;
   localparam int DIGITS_DEF       = 4;
   localparam int DIGIT_W          = 4;
   localparam int PASS_W           = 16;
   localparam int ROM_AW           = 5;

   typedef enum logic [3:0] {
      IDLE,
      DIGITENTRY,
      FETCH,
      ROMWAIT1,
      ROMWAIT2,
      CATCH,
      COMPARE,
      GRANTED,
      LOGOUT
   } pass_state_t;

   // Stored passwords, four words per user slot, MSD first; slots line up with the ID ROM.
   function automatic logic [DIGIT_W-1:0] rom_word(input logic [ROM_AW-1:0] a);
      logic [DIGIT_W-1:0] w;
      case (a)
         5'd0:    w = 4'h0;
         5'd1:    w = 4'h0;
         5'd2:    w = 4'h0;
         5'd3:    w = 4'h0;
         5'd4:    w = 4'h1;
         5'd5:    w = 4'h2;
         5'd6:    w = 4'h3;
         5'd7:    w = 4'h4;
         5'd8:    w = 4'h9;
         5'd9:    w = 4'h8;
         5'd10:   w = 4'h7;
         5'd11:   w = 4'h6;
         5'd12:   w = 4'h5;
         5'd13:   w = 4'h5;
         5'd14:   w = 4'h0;
         5'd15:   w = 4'h2;
         default: w = 4'h0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/password_controller_if.sv
// Keypad / ID-stage handshake bundle for the password controller.
interface password_controller_if;
   import pass_pkg::*;

   logic                Game_Enter;
   logic [DIGIT_W-1:0]  User_digit;
   logic                MatchedID;
   logic [ROM_AW-1:0]   InternalID;
   logic                Guest;
   logic                UserLogOut;
   logic                PassOK;
   logic                LogOut;
   logic [1:0]          AttemptsLeft;

   modport master (
      output Game_Enter, User_digit, MatchedID, InternalID, Guest, UserLogOut,
      input  PassOK, LogOut, AttemptsLeft
   );

   modport slave (
      input  Game_Enter, User_digit, MatchedID, InternalID, Guest, UserLogOut,
      output PassOK, LogOut, AttemptsLeft
   );
endinterface

// File: rtl/pass_rom.sv
// 32x4 synchronous password ROM: registered address, registered data.
module pass_rom
   import pass_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [ROM_AW-1:0]  addr,
   output logic [DIGIT_W-1:0] q
);

   logic [ROM_AW-1:0] addr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
         q      <= '0;
      end else begin
         addr_q <= addr;
         q      <= rom_word(addr_q);
      end
   end

endmodule

// File: rtl/password_controller.sv
// Password stage: collects keypad digits, fetches the stored password, grants or logs out.
//
// state      | meaning
// IDLE       | waiting for an accepted user ID
// DIGITENTRY | shifting in keypad digits
// FETCH      | load ROM address for digit index
// ROMWAIT1   | ROM address register latency
// ROMWAIT2   | ROM data register latency
// CATCH      | shift ROM digit into stored password
// COMPARE    | entered vs stored, spend an attempt on mismatch
// GRANTED    | session open, PassOK high
// LOGOUT     | LogOut high until the ID stage drops MatchedID
module password_controller
   import pass_pkg::*;
#(
   parameter int MAX_ATTEMPTS = MAX_ATTEMPTS_DEF,
   parameter int DIGITS       = DIGITS_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   password_controller_if.slave   bus
);

   localparam int PW = DIGIT_W * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
   localparam logic [1:0]    ATT_INIT = 2'(MAX_ATTEMPTS);

   pass_state_t        state;
   logic [CW-1:0]      dig_cnt;
   logic [CW-1:0]      idx;
   logic [PW-1:0]      user_pass;
   logic [PW-1:0]      rom_pass;
   logic [ROM_AW-1:0]  rom_addr;
   logic [DIGIT_W-1:0] q_rom;
   logic               pass_ok_q;
   logic               log_out_q;
   logic [1:0]         att_q;

   pass_rom u_rom (
      .clk  (clk),
      .rst  (rst),
      .addr (rom_addr),
      .q    (q_rom)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         dig_cnt   <= '0;
         idx       <= '0;
         user_pass <= '0;
         rom_pass  <= '0;
         rom_addr  <= '0;
         pass_ok_q <= 1'b0;
         log_out_q <= 1'b0;
         att_q     <= ATT_INIT;
      end else if (!bus.MatchedID && state != LOGOUT) begin
         // losing the ID anywhere outside LOGOUT is a full soft reset
         state     <= IDLE;
         dig_cnt   <= '0;
         idx       <= '0;
         user_pass <= '0;
         rom_pass  <= '0;
         rom_addr  <= '0;
         pass_ok_q <= 1'b0;
         log_out_q <= 1'b0;
         att_q     <= ATT_INIT;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Guest) begin
                  state <= GRANTED;
               end else begin
                  state     <= DIGITENTRY;
                  dig_cnt   <= '0;
                  user_pass <= '0;
                  rom_pass  <= '0;
               end
            end
            DIGITENTRY: begin
               if (bus.Game_Enter) begin
                  user_pass <= {user_pass[PW-DIGIT_W-1:0], bus.User_digit};
                  if (dig_cnt == LAST) begin
                     state   <= FETCH;
                     dig_cnt <= '0;
                     idx     <= '0;
                  end else begin
                     dig_cnt <= dig_cnt + 1'b1;
                  end
               end
            end
            FETCH: begin
               rom_addr <= bus.InternalID + ROM_AW'(idx);
               state    <= ROMWAIT1;
            end
            ROMWAIT1: state <= ROMWAIT2;
            ROMWAIT2: state <= CATCH;
            CATCH: begin
               rom_pass <= {rom_pass[PW-DIGIT_W-1:0], q_rom};
               if (idx == LAST) begin
                  state <= COMPARE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= FETCH;
               end
            end
            COMPARE: begin
               if (user_pass == rom_pass) begin
                  state <= GRANTED;
               end else begin
                  att_q <= att_q - 2'd1;
                  if (att_q == 2'd1) begin
                     state     <= LOGOUT;
                     log_out_q <= 1'b1;
                  end else begin
                     state     <= DIGITENTRY;
                     user_pass <= '0;
                     rom_pass  <= '0;
                     dig_cnt   <= '0;
                  end
               end
            end
            GRANTED: begin
               if (bus.UserLogOut) begin
                  state     <= LOGOUT;
                  log_out_q <= 1'b1;
                  pass_ok_q <= 1'b0;
               end else begin
                  pass_ok_q <= 1'b1;
               end
            end
            LOGOUT: begin
               pass_ok_q <= 1'b0;
               if (!bus.MatchedID) begin
                  state     <= IDLE;
                  log_out_q <= 1'b0;
                  att_q     <= ATT_INIT;
                  user_pass <= '0;
                  rom_pass  <= '0;
               end else begin
                  log_out_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.PassOK       = pass_ok_q;
   assign bus.LogOut       = log_out_q;
   assign bus.AttemptsLeft = att_q;

endmodule

// File: tb/tb_password_controller.sv
// Directed bench for password_controller: login, retries, lockout, guest, ID loss, async reset.
module tb_password_controller;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   password_controller_if bus();

   password_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_digit(input int d);
      bus.User_digit = 4'(d);
      bus.Game_Enter = 1'b1;
      tick();
      bus.Game_Enter = 1'b0;
   endtask

   task automatic enter(input int a, input int b, input int c, input int d);
      send_digit(a);
      send_digit(b);
      send_digit(c);
      send_digit(d);
   endtask

   // After the 4th digit edge: PassOK low on edge 17, high on edge 18.
   task automatic expect_grant(input string tag);
      repeat (17) tick();
      chk({tag, "_pre"}, int'(bus.PassOK), 0);
      tick();
      chk({tag, "_ok"}, int'(bus.PassOK), 1);
   endtask

   // After the 4th digit edge: compare result is visible on edge 17.
   task automatic expect_reject(input string tag, input int att);
      repeat (17) tick();
      chk({tag, "_ok"}, int'(bus.PassOK), 0);
      chk({tag, "_att"}, int'(bus.AttemptsLeft), att);
   endtask

   initial begin
      bus.Game_Enter = 1'b0;
      bus.User_digit = '0;
      bus.MatchedID  = 1'b0;
      bus.InternalID = 5'd4;
      bus.Guest      = 1'b0;
      bus.UserLogOut = 1'b0;

      repeat (3) tick();
      chk("rst_passok", int'(bus.PassOK), 0);
      chk("rst_logout", int'(bus.LogOut), 0);
      chk("rst_att", int'(bus.AttemptsLeft), 3);
      rst = 1'b1;
      tick();

      // correct password, with a stray digit pulse while in FETCH
      bus.MatchedID = 1'b1;
      tick();
      enter(1, 2, 3, 4);
      bus.User_digit = 4'd9;
      bus.Game_Enter = 1'b1;
      tick();
      bus.Game_Enter = 1'b0;
      repeat (16) tick();
      chk("good_pre", int'(bus.PassOK), 0);
      tick();
      chk("good_ok", int'(bus.PassOK), 1);
      chk("good_att", int'(bus.AttemptsLeft), 3);
      bus.UserLogOut = 1'b1;
      tick();
      bus.UserLogOut = 1'b0;
      chk("ulo_logout", int'(bus.LogOut), 1);
      chk("ulo_passok", int'(bus.PassOK), 0);
      bus.MatchedID = 1'b0;
      tick();
      chk("ulo_release", int'(bus.LogOut), 0);
      chk("ulo_att", int'(bus.AttemptsLeft), 3);

      // one wrong attempt, then the right one
      bus.MatchedID = 1'b1;
      tick();
      enter(1, 2, 3, 5);
      expect_reject("retry1", 2);
      chk("retry1_logout", int'(bus.LogOut), 0);
      enter(1, 2, 3, 4);
      expect_grant("retry2");
      chk("retry2_att", int'(bus.AttemptsLeft), 2);
      bus.MatchedID = 1'b0;
      tick();
      chk("drop_grant_passok", int'(bus.PassOK), 0);
      chk("drop_grant_att", int'(bus.AttemptsLeft), 3);

      // lockout after three wrong attempts
      bus.MatchedID = 1'b1;
      tick();
      enter(0, 0, 0, 0);
      expect_reject("lock1", 2);
      enter(4, 3, 2, 1);
      expect_reject("lock2", 1);
      enter(1, 2, 3, 0);
      expect_reject("lock3", 0);
      chk("lock_logout", int'(bus.LogOut), 1);
      repeat (4) tick();
      chk("lock_hold", int'(bus.LogOut), 1);
      bus.MatchedID = 1'b0;
      tick();
      chk("lock_release", int'(bus.LogOut), 0);
      chk("lock_reload", int'(bus.AttemptsLeft), 3);

      // guest bypass
      bus.MatchedID = 1'b1;
      bus.Guest     = 1'b1;
      tick();
      chk("guest_1cyc", int'(bus.PassOK), 0);
      tick();
      chk("guest_2cyc", int'(bus.PassOK), 1);
      bus.UserLogOut = 1'b1;
      tick();
      bus.UserLogOut = 1'b0;
      chk("guest_logout", int'(bus.LogOut), 1);
      chk("guest_passok", int'(bus.PassOK), 0);
      bus.MatchedID = 1'b0;
      bus.Guest     = 1'b0;
      tick();
      chk("guest_release", int'(bus.LogOut), 0);

      // ID lost in ROMWAIT2 after one spent attempt
      bus.MatchedID = 1'b1;
      tick();
      enter(0, 0, 0, 0);
      expect_reject("mid_wrong", 2);
      enter(1, 2, 3, 4);
      tick();
      tick();
      bus.MatchedID = 1'b0;
      tick();
      chk("mid_passok", int'(bus.PassOK), 0);
      chk("mid_logout", int'(bus.LogOut), 0);
      chk("mid_att", int'(bus.AttemptsLeft), 3);
      bus.MatchedID = 1'b1;
      tick();
      enter(1, 2, 3, 4);
      expect_grant("mid_again");

      // asynchronous reset while granted
      #3;
      rst = 1'b0;
      #1;
      chk("arst_passok", int'(bus.PassOK), 0);
      chk("arst_att", int'(bus.AttemptsLeft), 3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      enter(1, 2, 3, 4);
      expect_grant("arst_idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
